vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; successor to the fixed 640x480 timing block. Generates HS/VS/BLANK for any mode, configurable sync polarity, pixel replication (scaled framebuffer), and a double-buffered framebuffer read address with a vblank-synchronised swap handshake. Sits between the pixel clock domain and the video RAM read port; the RAM has 1-cycle read latency.

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_axis_counter.sv | 34 +++
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 mode, sync polarity constants and axis region type.
package vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit POL_LOW      = 1'b0;
    localparam bit POL_HIGH     = 1'b1;
    typedef enum logic [1:0] {R_ACTIVE, R_FP, R_SYNC, R_BP} region_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (active, front porch, sync, back porch) with region and wrap.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output region_t       o_region,
    output logic          o_wrap
);
    localparam logic [CW-1:0] LAST   = CW'(ACTIVE + FP + SYNC + BP - 1);
    localparam logic [CW-1:0] E_ACT  = CW'(ACTIVE);
    localparam logic [CW-1:0] E_FP   = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] E_SYNC = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] r_count;

    assign o_count = r_count;
    assign o_wrap  = i_en && r_count == LAST;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_count <= '0;
        else if (i_en) r_count <= o_wrap ? '0 : r_count + 1'b1;

    always_comb
        o_region = r_count < E_ACT ? R_ACTIVE : r_count < E_FP ? R_FP : r_count < E_SYNC ? R_SYNC : R_BP;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel replication and a
// double-buffered framebuffer address whose swap is taken only at the start of vblank.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = POL_LOW,
    parameter bit VS_POL     = POL_LOW,
    parameter int SCALE_LOG2 = 0,
    parameter int ADDR_W     = 19
) (
    input  logic              clk25MHz,
    input  logic              rst_n,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic [9:0]        xpix,
    output logic [8:0]        ypix,
    output logic [ADDR_W-1:0] addr_lead,
    output logic              frame_start,
    output logic              vblank_start
);
    localparam int HCW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VCW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int BUF_WORDS = (H_ACTIVE >> SCALE_LOG2) * (V_ACTIVE >> SCALE_LOG2);
    localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(H_ACTIVE >> SCALE_LOG2);
    localparam logic [ADDR_W-1:0] BUF_BASE  = ADDR_W'(BUF_WORDS);
    localparam logic [VCW-1:0]    V_MASK    = VCW'((1 << SCALE_LOG2) - 1);
    localparam logic [VCW-1:0]    V_VBL     = VCW'(V_ACTIVE);

    logic [HCW-1:0]    w_hcnt;
    logic [VCW-1:0]    w_vcnt;
    region_t           w_hreg, w_vreg;
    logic              w_hwrap, w_vwrap, w_active, w_vbl_pix, w_row_adv, w_swap;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] r_row_base;

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(HCW)) u_h (
        .i_clk(clk25MHz), .i_rst_n(rst_n), .i_en(1'b1),
        .o_count(w_hcnt), .o_region(w_hreg), .o_wrap(w_hwrap)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(VCW)) u_v (
        .i_clk(clk25MHz), .i_rst_n(rst_n), .i_en(w_hwrap),
        .o_count(w_vcnt), .o_region(w_vreg), .o_wrap(w_vwrap)
    );

    assign w_active  = w_hreg == R_ACTIVE && w_vreg == R_ACTIVE;
    assign w_vbl_pix = w_hcnt == '0 && w_vcnt == V_VBL;
    assign w_swap    = w_vbl_pix && swap_req;
    // Replicated lines reuse the same row until the last copy of the row finishes.
    assign w_row_adv = w_hwrap && w_vreg == R_ACTIVE && ((w_vcnt + 1'b1) & V_MASK) == '0;
    assign w_base    = front_buf ? BUF_BASE : '0;
    assign addr_lead = w_active ? w_base + r_row_base + ADDR_W'(w_hcnt >> SCALE_LOG2) : w_base;
    assign VGA_SYNC_N = 1'b0;

    always_ff @(posedge clk25MHz or negedge rst_n)
        if (!rst_n) r_row_base <= '0;
        else if (w_vwrap) r_row_base <= '0;
        else if (w_row_adv) r_row_base <= r_row_base + ROW_WORDS;

    always_ff @(posedge clk25MHz or negedge rst_n)
        if (!rst_n) begin
            VGA_HS       <= ~HS_POL;
            VGA_VS       <= ~VS_POL;
            VGA_BLANK_N  <= 1'b0;
            xpix         <= '0;
            ypix         <= '0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            swap_ack     <= 1'b0;
            front_buf    <= 1'b0;
        end else begin
            VGA_HS       <= w_hreg == R_SYNC ? HS_POL : ~HS_POL;
            VGA_VS       <= w_vreg == R_SYNC ? VS_POL : ~VS_POL;
            VGA_BLANK_N  <= w_active;
            xpix         <= w_active ? 10'(w_hcnt >> SCALE_LOG2) : '0;
            ypix         <= w_active ? 9'(w_vcnt >> SCALE_LOG2) : '0;
            frame_start  <= w_hcnt == '0 && w_vcnt == '0;
            vblank_start <= w_vbl_pix;
            swap_ack     <= w_swap;
            front_buf    <= front_buf ^ w_swap;
        end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a small 16x11 mode (scale 1 and 2) and the default mode with HS_POL=1.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_s = 1'b0, rst_d = 1'b0;
    logic swap_s0 = 1'b0, swap_s1 = 1'b0, swap_d = 1'b0;
    int checks = 0, errors = 0, t = 0;

    logic ack_s0, fb_s0, hs_s0, vs_s0, bl_s0, sn_s0, fs_s0, vb_s0;
    logic [9:0] x_s0;
    logic [8:0] y_s0;
    logic [7:0] a_s0;
    logic ack_s1, fb_s1, hs_s1, vs_s1, bl_s1, sn_s1, fs_s1, vb_s1;
    logic [9:0] x_s1;
    logic [8:0] y_s1;
    logic [7:0] a_s1;
    logic ack_d, fb_d, hs_d, vs_d, bl_d, sn_d, fs_d, vb_d;
    logic [9:0] x_d;
    logic [8:0] y_d;
    logic [18:0] a_d;

    always #5 clk = ~clk;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                     .SCALE_LOG2(0), .ADDR_W(8)) u_s0 (
        .clk25MHz(clk), .rst_n(rst_s), .swap_req(swap_s0), .swap_ack(ack_s0), .front_buf(fb_s0),
        .VGA_HS(hs_s0), .VGA_VS(vs_s0), .VGA_BLANK_N(bl_s0), .VGA_SYNC_N(sn_s0), .xpix(x_s0), .ypix(y_s0),
        .addr_lead(a_s0), .frame_start(fs_s0), .vblank_start(vb_s0));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                     .SCALE_LOG2(1), .ADDR_W(8)) u_s1 (
        .clk25MHz(clk), .rst_n(rst_s), .swap_req(swap_s1), .swap_ack(ack_s1), .front_buf(fb_s1),
        .VGA_HS(hs_s1), .VGA_VS(vs_s1), .VGA_BLANK_N(bl_s1), .VGA_SYNC_N(sn_s1), .xpix(x_s1), .ypix(y_s1),
        .addr_lead(a_s1), .frame_start(fs_s1), .vblank_start(vb_s1));

    vga_timing_gen #(.HS_POL(1'b1)) u_d (
        .clk25MHz(clk), .rst_n(rst_d), .swap_req(swap_d), .swap_ack(ack_d), .front_buf(fb_d),
        .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_BLANK_N(bl_d), .VGA_SYNC_N(sn_d), .xpix(x_d), .ypix(y_d),
        .addr_lead(a_d), .frame_start(fs_d), .vblank_start(vb_d));

    task automatic step;
        @(negedge clk);
        t++;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if ({bl_s0, hs_s0, vs_s0, fs_s0, vb_s0, ack_s0, fb_s0, sn_s0} !== 8'b0110_0000) begin errors++; $display("FAIL reset_flags_s0 got %b exp 01100000", {bl_s0, hs_s0, vs_s0, fs_s0, vb_s0, ack_s0, fb_s0, sn_s0}); end
        checks++; if (x_s0 !== 10'd0 || y_s0 !== 9'd0 || a_s0 !== 8'd0) begin errors++; $display("FAIL reset_xy_addr_s0 got %0d %0d %0d exp 0 0 0", x_s0, y_s0, a_s0); end
        checks++; if ({bl_d, hs_d, vs_d, fs_d} !== 4'b0010) begin errors++; $display("FAIL reset_flags_d got %b exp 0010", {bl_d, hs_d, vs_d, fs_d}); end
        checks++; if (a_d !== 19'd0 || a_s1 !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d %0d exp 0 0", a_d, a_s1); end
        rst_s = 1'b1;
        rst_d = 1'b1;
        t = 0;
    endtask

    task automatic test_first_edge;
        step();
        checks++; if (bl_s0 !== 1'b1 || fs_s0 !== 1'b1) begin errors++; $display("FAIL first_edge_s0 got bl=%b fs=%b exp 1 1", bl_s0, fs_s0); end
        checks++; if (x_s0 !== 10'd0 || y_s0 !== 9'd0) begin errors++; $display("FAIL first_edge_xy got %0d %0d exp 0 0", x_s0, y_s0); end
        checks++; if (a_s0 !== 8'd1) begin errors++; $display("FAIL first_edge_addr got %0d exp 1", a_s0); end
        checks++; if (fs_d !== 1'b1 || bl_d !== 1'b1) begin errors++; $display("FAIL first_edge_d got fs=%b bl=%b exp 1 1", fs_d, bl_d); end
    endtask

    task automatic test_timing_small;
        int hs_n = 0, vs_n = 0, bl_n = 0, fs_n = 0, vb_n = 0;
        int row_tab [6] = '{0, 0, 4, 4, 8, 8};
        int p, h, v, q, hq, vq;
        logic e_hs, e_vs, e_bl;
        logic [7:0] e_a0, e_a1;
        repeat (176) begin
            step();
            p = (t - 1) % 176; h = p % 16; v = p / 16;
            q = t % 176; hq = q % 16; vq = q / 16;
            e_hs = !(h >= 10 && h <= 12);
            e_vs = !(v >= 7 && v <= 8);
            e_bl = h < 8 && v < 6;
            e_a0 = (hq < 8 && vq < 6) ? 8'(vq * 8 + hq) : 8'd0;
            e_a1 = (hq < 8 && vq < 6) ? 8'(row_tab[vq] + hq / 2) : 8'd0;
            hs_n += int'(hs_s0 == 1'b0); vs_n += int'(vs_s0 == 1'b0); bl_n += int'(bl_s0 == 1'b1);
            fs_n += int'(fs_s0 == 1'b1); vb_n += int'(vb_s0 == 1'b1);
            checks++; if ({hs_s0, vs_s0, bl_s0} !== {e_hs, e_vs, e_bl}) begin errors++; $display("FAIL sync_s0 t=%0d got %b exp %b", t, {hs_s0, vs_s0, bl_s0}, {e_hs, e_vs, e_bl}); end
            checks++; if (x_s0 !== 10'(e_bl ? h : 0) || y_s0 !== 9'(e_bl ? v : 0)) begin errors++; $display("FAIL xy_s0 t=%0d got %0d,%0d", t, x_s0, y_s0); end
            checks++; if (a_s0 !== e_a0) begin errors++; $display("FAIL addr_s0 t=%0d got %0d exp %0d", t, a_s0, e_a0); end
            checks++; if (a_s1 !== e_a1) begin errors++; $display("FAIL addr_s1 t=%0d got %0d exp %0d", t, a_s1, e_a1); end
            checks++; if (x_s1 !== 10'(e_bl ? h / 2 : 0) || y_s1 !== 9'(e_bl ? v / 2 : 0)) begin errors++; $display("FAIL xy_s1 t=%0d got %0d,%0d", t, x_s1, y_s1); end
            if (t == 35) begin checks++; if (a_s0 !== 8'd19) begin errors++; $display("FAIL addr_3_2 got %0d exp 19", a_s0); end end
            if (t == 36) begin checks++; if (x_s0 !== 10'd3 || y_s0 !== 9'd2) begin errors++; $display("FAIL pix_3_2 got %0d,%0d exp 3,2", x_s0, y_s0); end end
            if (t == 10) begin checks++; if (a_s0 !== 8'd0) begin errors++; $display("FAIL addr_outside got %0d exp 0", a_s0); end end
        end
        checks++; if (hs_n !== 33 || vs_n !== 32) begin errors++; $display("FAIL sync_counts got hs=%0d vs=%0d exp 33 32", hs_n, vs_n); end
        checks++; if (bl_n !== 48) begin errors++; $display("FAIL blank_count got %0d exp 48", bl_n); end
        checks++; if (fs_n !== 1 || vb_n !== 1) begin errors++; $display("FAIL pulse_counts got fs=%0d vb=%0d exp 1 1", fs_n, vb_n); end
    endtask

    task automatic test_swap;
        int acks = 0;
        swap_s0 = 1'b1;
        while (t < 354) begin
            step();
            acks += int'(ack_s0 == 1'b1);
            if (t == 272) begin checks++; if (fb_s0 !== 1'b0 || ack_s0 !== 1'b0) begin errors++; $display("FAIL swap_early got fb=%b ack=%b exp 0 0", fb_s0, ack_s0); end end
            if (t == 273) begin
                checks++; if (fb_s0 !== 1'b1 || ack_s0 !== 1'b1 || vb_s0 !== 1'b1) begin errors++; $display("FAIL swap_take got fb=%b ack=%b vb=%b exp 1 1 1", fb_s0, ack_s0, vb_s0); end
                swap_s0 = 1'b0;
            end
            if (t == 274) begin checks++; if (fb_s0 !== 1'b1 || ack_s0 !== 1'b0) begin errors++; $display("FAIL swap_after got fb=%b ack=%b exp 1 0", fb_s0, ack_s0); end end
            if (t == 352) begin checks++; if (a_s0 !== 8'd48) begin errors++; $display("FAIL swap_addr0 got %0d exp 48", a_s0); end end
            if (t == 353) begin checks++; if (a_s0 !== 8'd49 || fs_s0 !== 1'b1) begin errors++; $display("FAIL swap_addr1 got %0d fs=%b exp 49 1", a_s0, fs_s0); end end
        end
        checks++; if (acks !== 1) begin errors++; $display("FAIL swap_ack_count got %0d exp 1", acks); end
    endtask

    task automatic test_swap_held;
        int acks = 0;
        swap_s0 = 1'b1;
        while (t < 626) begin
            step();
            acks += int'(ack_s0 == 1'b1);
            if (t == 449) begin checks++; if (fb_s0 !== 1'b0 || ack_s0 !== 1'b1) begin errors++; $display("FAIL held_first got fb=%b ack=%b exp 0 1", fb_s0, ack_s0); end end
            if (t == 450) begin checks++; if (ack_s0 !== 1'b0) begin errors++; $display("FAIL held_pulse got ack=%b exp 0", ack_s0); end end
            if (t == 625) begin checks++; if (fb_s0 !== 1'b1 || ack_s0 !== 1'b1) begin errors++; $display("FAIL held_second got fb=%b ack=%b exp 1 1", fb_s0, ack_s0); end end
        end
        checks++; if (acks !== 2) begin errors++; $display("FAIL held_ack_count got %0d exp 2", acks); end
        swap_s0 = 1'b0;
    endtask

    task automatic test_no_swap;
        int acks = 0;
        while (t < 810) begin
            step();
            acks += int'(ack_s0 == 1'b1) + int'(ack_s1 == 1'b1);
        end
        checks++; if (acks !== 0 || fb_s0 !== 1'b1 || fb_s1 !== 1'b0) begin errors++; $display("FAIL no_swap got acks=%0d fb0=%b fb1=%b exp 0 1 0", acks, fb_s0, fb_s1); end
    endtask

    task automatic test_async_reset_polarity;
        int u = 0;
        checks++; if (bl_d !== 1'b1 || x_d !== 10'd9 || y_d !== 9'd1) begin errors++; $display("FAIL pre_reset_d got bl=%b x=%0d y=%0d exp 1 9 1", bl_d, x_d, y_d); end
        #2 rst_d = 1'b0;
        #1;
        checks++; if ({bl_d, hs_d, vs_d, fs_d, fb_d} !== 5'b00100) begin errors++; $display("FAIL async_reset got %b exp 00100", {bl_d, hs_d, vs_d, fs_d, fb_d}); end
        checks++; if (x_d !== 10'd0 || y_d !== 9'd0 || a_d !== 19'd0) begin errors++; $display("FAIL async_reset_xy got %0d %0d %0d exp 0 0 0", x_d, y_d, a_d); end
        @(negedge clk);
        checks++; if (bl_d !== 1'b0 || a_d !== 19'd0) begin errors++; $display("FAIL reset_held got bl=%b addr=%0d exp 0 0", bl_d, a_d); end
        rst_d = 1'b1;
        while (u < 760) begin
            @(negedge clk);
            u++;
            if (u == 1) begin checks++; if (fs_d !== 1'b1 || bl_d !== 1'b1 || x_d !== 10'd0 || y_d !== 9'd0 || a_d !== 19'd1) begin errors++; $display("FAIL restart got fs=%b bl=%b x=%0d y=%0d a=%0d", fs_d, bl_d, x_d, y_d, a_d); end end
            if (u == 2) begin checks++; if (fs_d !== 1'b0) begin errors++; $display("FAIL restart_pulse got %b exp 0", fs_d); end end
            if (u == 640) begin checks++; if (x_d !== 10'd639 || bl_d !== 1'b1) begin errors++; $display("FAIL last_pix got x=%0d bl=%b exp 639 1", x_d, bl_d); end end
            if (u == 641) begin checks++; if (x_d !== 10'd0 || bl_d !== 1'b0) begin errors++; $display("FAIL fp_pix got x=%0d bl=%b exp 0 0", x_d, bl_d); end end
            if (u == 656) begin checks++; if (hs_d !== 1'b0) begin errors++; $display("FAIL hs_before got %b exp 0", hs_d); end end
            if (u == 657) begin checks++; if (hs_d !== 1'b1 || vs_d !== 1'b1 || sn_d !== 1'b0) begin errors++; $display("FAIL hs_pol got hs=%b vs=%b sn=%b exp 1 1 0", hs_d, vs_d, sn_d); end end
            if (u == 752) begin checks++; if (hs_d !== 1'b1) begin errors++; $display("FAIL hs_last got %b exp 1", hs_d); end end
            if (u == 753) begin checks++; if (hs_d !== 1'b0) begin errors++; $display("FAIL hs_after got %b exp 0", hs_d); end end
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_timing_small();
        test_swap();
        test_swap_held();
        test_no_swap();
        test_async_reset_polarity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
